// File: rtl/adder_pkg.sv
// Shared constants for the bit-serial adder/subtractor.
// FSM state codes and the default operand width.
package adder_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/Full_Adder.sv
// Gate-level one-bit full adder cell.
// Ports: a, b, cin in; sum, cout out.
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic x;
  logic g;
  logic p;

  xor u_x0 (x, a, b);
  xor u_x1 (sum, x, cin);
  and u_a0 (g, a, b);
  and u_a1 (p, x, cin);
  or  u_o0 (cout, g, p);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, one bit per clock, LSB first.
// Ports: clk, rst_n, start, sub, a, b, cin in;
// busy, done, sum, cout, overflow out.
module serial_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int IW = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             carry;
  logic             fs;
  logic             fc;
  logic             last;

  Full_Adder u_fa (
    .a    (areg[0]),
    .b    (breg[0]),
    .cin  (carry),
    .sum  (fs),
    .cout (fc)
  );

  assign last = (idx == IW'(WIDTH - 1));
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      areg     <= '0;
      breg     <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Subtract as a + ~b + ~borrow.
            areg     <= a;
            breg     <= sub ? ~b : b;
            carry    <= sub ? ~cin : cin;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          areg  <= areg >> 1;
          breg  <= breg >> 1;
          carry <= fc;
          idx   <= idx + IW'(1);
          for (int j = 0; j < WIDTH; j++) begin
            if (idx == IW'(j)) sum[j] <= fs;
          end
          if (last) begin
            cout     <= fc;
            overflow <= carry ^ fc;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and swept checks of serial_addsub at widths 1, 8, 32.
// No ports; prints one summary line.
module tb_serial_addsub;

  logic clk;
  logic rst_n;

  logic        st8, sb8, ci8, bz8, dn8, co8, ov8;
  logic [7:0]  a8, b8, s8;
  logic        st1, sb1, ci1, bz1, dn1, co1, ov1;
  logic [0:0]  a1, b1, s1;
  logic        st32, sb32, ci32, bz32, dn32, co32, ov32;
  logic [31:0] a32, b32, s32;

  int checks = 0;
  int errors = 0;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .sub(sb8),
    .a(a8), .b(b8), .cin(ci8), .busy(bz8), .done(dn8),
    .sum(s8), .cout(co8), .overflow(ov8)
  );

  serial_addsub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .sub(sb1),
    .a(a1), .b(b1), .cin(ci1), .busy(bz1), .done(dn1),
    .sum(s1), .cout(co1), .overflow(ov1)
  );

  serial_addsub #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(st32), .sub(sb32),
    .a(a32), .b(b32), .cin(ci32), .busy(bz32), .done(dn32),
    .sum(s32), .cout(co32), .overflow(ov32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model(input int w,
                       input logic [31:0] av, bv,
                       input logic sv, cv,
                       output logic [31:0] es,
                       output logic ec, eo);
    logic [31:0] m;
    logic [31:0] be;
    logic [32:0] t;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    be = (sv ? ~bv : bv) & m;
    t  = {1'b0, av & m} + {1'b0, be} + {32'h0, sv ^ cv};
    es = t[31:0] & m;
    ec = t[w];
    eo = (av[w-1] == be[w-1]) && (es[w-1] != av[w-1]);
  endtask

  task automatic drive(input int w,
                       input logic [31:0] av, bv,
                       input logic sv, cv, sg);
    case (w)
      1: begin a1 = av[0:0]; b1 = bv[0:0]; sb1 = sv; ci1 = cv; st1 = sg; end
      8: begin a8 = av[7:0]; b8 = bv[7:0]; sb8 = sv; ci8 = cv; st8 = sg; end
      default: begin a32 = av; b32 = bv; sb32 = sv; ci32 = cv; st32 = sg; end
    endcase
  endtask

  function automatic logic o_done(input int w);
    return (w == 1) ? dn1 : (w == 8) ? dn8 : dn32;
  endfunction

  function automatic logic o_busy(input int w);
    return (w == 1) ? bz1 : (w == 8) ? bz8 : bz32;
  endfunction

  function automatic logic o_cout(input int w);
    return (w == 1) ? co1 : (w == 8) ? co8 : co32;
  endfunction

  function automatic logic o_ovf(input int w);
    return (w == 1) ? ov1 : (w == 8) ? ov8 : ov32;
  endfunction

  function automatic logic [31:0] o_sum(input int w);
    return (w == 1) ? {31'h0, s1} : (w == 8) ? {24'h0, s8} : s32;
  endfunction

  task automatic run(input int w,
                     input logic [31:0] av, bv,
                     input logic sv, cv);
    logic [31:0] es;
    logic        ec, eo;
    int          n;
    string       t;
    model(w, av, bv, sv, cv, es, ec, eo);
    t = $sformatf("w%0d_%h_%h_s%0d_c%0d", w, av, bv, sv, cv);
    @(negedge clk);
    drive(w, av, bv, sv, cv, 1'b1);
    @(posedge clk);
    #1;
    drive(w, av, bv, sv, cv, 1'b0);
    n = 0;
    while (!o_done(w) && n < w + 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({t, "_lat"}, n, w);
    chk({t, "_sum"}, o_sum(w), es);
    chk({t, "_cout"}, {31'h0, o_cout(w)}, {31'h0, ec});
    chk({t, "_ovf"}, {31'h0, o_ovf(w)}, {31'h0, eo});
    @(posedge clk);
    #1;
    chk({t, "_idle"}, {30'h0, o_busy(w), o_done(w)}, 32'h0);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    drive(8, 0, 0, 0, 0, 0);
    drive(32, 0, 0, 0, 0, 0);
    #3;
    chk("rst_outs", {20'h0, bz8, dn8, s8, co8, ov8}, 32'h0);
    chk("rst_w32", s32, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed width-8 vectors with hand-computed results.
    run(8, 32'hFF, 32'h01, 1'b0, 1'b0);
    chk("d_ff01", {23'h0, s8, co8}, {23'h0, 8'h00, 1'b1});
    run(8, 32'h7F, 32'h01, 1'b0, 1'b0);
    chk("d_7f01", {22'h0, s8, co8, ov8}, {22'h0, 8'h80, 1'b0, 1'b1});
    run(8, 32'h80, 32'h80, 1'b0, 1'b0);
    chk("d_8080", {22'h0, s8, co8, ov8}, {22'h0, 8'h00, 1'b1, 1'b1});
    run(8, 32'h05, 32'h07, 1'b1, 1'b0);
    chk("d_0507", {22'h0, s8, co8, ov8}, {22'h0, 8'hFE, 1'b0, 1'b0});
    run(8, 32'h05, 32'h02, 1'b1, 1'b1);
    chk("d_0502", {23'h0, s8, co8}, {23'h0, 8'h02, 1'b1});

    // Start and operand churn during RUN: 3C+55+1 = 92, signed ovf.
    @(negedge clk);
    drive(8, 32'h3C, 32'h55, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (dn8) pulses++;
      if (k < 6)
        drive(8, $urandom, $urandom, 1'($urandom), 1'($urandom), k[0]);
      else
        st8 = 1'b0;
      @(posedge clk);
    end
    #1;
    chk("churn_pulses", pulses, 1);
    chk("churn_res", {22'h0, s8, co8, ov8}, {22'h0, 8'h92, 1'b0, 1'b1});

    // Reset while processing bit 3.
    @(negedge clk);
    drive(8, 32'h12, 32'h34, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    st8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {20'h0, bz8, dn8, s8, co8, ov8}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (dn8) pulses++;
    end
    chk("abort_pulses", pulses, 0);
    run(8, 32'h12, 32'h34, 1'b0, 1'b0);

    // Width 1: every input combination.
    for (int v = 0; v < 16; v++)
      run(1, 32'(v & 1), 32'((v >> 1) & 1), v[2], v[3]);

    // Width 32: corners then random.
    run(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    run(32, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    run(32, 32'h8000_0000, 32'h1, 1'b1, 1'b0);
    run(32, 32'h0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++)
      run(32, $urandom, $urandom, 1'($urandom), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
